// File: rtl/half_sub_pkg.sv
// ============================================================================
// Module   : half_sub_pkg
// Purpose  : Shared constants for the NAND-only half-subtractor block.
//            Optional macro HALF_SUB_PIPE2_EN selects a two-stage output pipe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package half_sub_pkg;

    localparam int HS_DEFAULT_WIDTH = 1;

`ifdef HALF_SUB_PIPE2_EN
    localparam int HS_LATENCY = 2;
`else
    localparam int HS_LATENCY = 1;
`endif

    // Number of NAND2 cells spent per lane; kept here so netlist audits agree.
    localparam int HS_NANDS_PER_LANE = 5;

endpackage : half_sub_pkg

`default_nettype wire

// File: rtl/hs_nand_lane.sv
// ============================================================================
// Module   : hs_nand_lane
// Purpose  : One-bit combinational half subtractor from five 2-input NANDs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hs_nand_lane (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    wire w_n1;
    wire w_n2;
    wire w_n3;

    nand u_n1 (w_n1, a,    b);
    nand u_n2 (w_n2, a,    w_n1);
    nand u_n3 (w_n3, b,    w_n1);
    nand u_n4 (diff, w_n2, w_n3);
    // w_n3 = ~(b & ~a); inverting it via a tied NAND yields ~a & b.
    nand u_n5 (bout, w_n3, w_n3);

endmodule : hs_nand_lane

`default_nettype wire

// File: rtl/half_subtractor_nand.sv
// ============================================================================
// Module   : half_subtractor_nand
// Purpose  : Registered lane-parallel NAND-only half subtractor with valid.
//            Macro HALF_SUB_PIPE2_EN adds a second register stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module half_subtractor_nand
    import half_sub_pkg::*;
#(
    parameter int WIDTH = HS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] bout
);

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_bout;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_diff;
    logic [WIDTH-1:0] r_s1_bout;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_lane
            hs_nand_lane u_lane (
                .a    (a[gi]),
                .b    (b[gi]),
                .diff (w_diff[gi]),
                .bout (w_bout[gi])
            );
        end
    endgenerate

    // Data is only captured under in_valid so idle-cycle garbage never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
            r_s1_bout  <= '0;
        end else if (in_valid) begin
            r_s1_valid <= 1'b1;
            r_s1_diff  <= w_diff;
            r_s1_bout  <= w_bout;
        end else begin
            r_s1_valid <= 1'b0;
        end
    end

`ifdef HALF_SUB_PIPE2_EN
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_diff;
    logic [WIDTH-1:0] r_s2_bout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_diff  <= '0;
            r_s2_bout  <= '0;
        end else if (r_s1_valid) begin
            r_s2_valid <= 1'b1;
            r_s2_diff  <= r_s1_diff;
            r_s2_bout  <= r_s1_bout;
        end else begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign diff      = r_s2_diff;
    assign bout      = r_s2_bout;
`else
    assign out_valid = r_s1_valid;
    assign diff      = r_s1_diff;
    assign bout      = r_s1_bout;
`endif

endmodule : half_subtractor_nand

`default_nettype wire

// File: tb/tb_half_subtractor_nand.sv
// ============================================================================
// Module   : tb_half_subtractor_nand
// Purpose  : Scoreboard bench for half_subtractor_nand (WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_half_subtractor_nand;
    import half_sub_pkg::*;

    localparam int W = 4;

    typedef struct {
        int           due;
        logic [W-1:0] d;
        logic [W-1:0] b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] diff;
    logic [W-1:0] bout;

    half_subtractor_nand #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    exp_t         q[$];
    int           cyc = 0;
    int           n_total = 0;
    int           n_pass = 0;
    logic [W-1:0] held_d = '0;
    logic [W-1:0] held_b = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    endtask

    // Reference: per lane, a - b taken mod 2 is the difference, negative means borrow.
    function automatic void ref_sub(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                    output logic [W-1:0] d, output logic [W-1:0] bo);
        for (int i = 0; i < W; i++) begin
            int x;
            x = int'(ai[i]) - int'(bi[i]);
            d[i]  = (x != 0);
            bo[i] = (x < 0);
        end
    endfunction

    // Drive one cycle's inputs, wait for the edge, then record what the DUT should do.
    task automatic step(input logic r, input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        rst = r; in_valid = v; a = av; b = bv;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            held_d = '0;
            held_b = '0;
        end else if (v) begin
            ref_sub(av, bv, e.d, e.b);
            e.due = cyc + HS_LATENCY - 1;
            q.push_back(e);
        end
        #1;
    endtask

    // Monitor: mid-cycle, compare presented outputs against the scoreboard.
    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                exp_v = (q.size() > 0) && (q[0].due == cyc);
                chk("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, exp_v});
                if (exp_v) begin
                    e = q.pop_front();
                    chk("diff", diff, e.d);
                    chk("bout", bout, e.b);
                    held_d = e.d;
                    held_b = e.b;
                end else begin
                    chk("diff_hold", diff, held_d);
                    chk("bout_hold", bout, held_b);
                end
            end
        end
    end

    initial begin
        #1;
        // Reset dominates a valid input.
        repeat (3) step(1'b1, 1'b1, '1, '1);
        // All four lane combinations, then mixed lanes.
        step(1'b0, 1'b1, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        step(1'b0, 1'b1, 4'b1100, 4'b1010);
        // Result diff=1,bout=1 on every lane, then idle with changing inputs.
        step(1'b0, 1'b1, 4'h0, 4'hF);
        step(1'b0, 1'b0, 4'hF, 4'h0);
        step(1'b0, 1'b0, 4'h5, 4'h3);
        step(1'b0, 1'b0, 4'hA, 4'h6);
        // Mid-stream reset then resume.
        step(1'b0, 1'b1, 4'h9, 4'h6);
        step(1'b0, 1'b1, 4'h3, 4'hC);
        step(1'b1, 1'b1, 4'hF, 4'h1);
        step(1'b0, 1'b1, 4'h6, 4'h5);
        step(1'b0, 1'b1, 4'h2, 4'hB);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom));
        end
        repeat (HS_LATENCY + 2) step(1'b0, 1'b0, W'($urandom), W'($urandom));
        chk("drain", W'(q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_half_subtractor_nand

`default_nettype wire
